stack_arb_ctrl: RTL

- Sequencing controller for the small LIFO stack used in the final project; owns the stack pointer and the storage array.
- Shares the stack between two requesters (port 0, port 1) with round-robin arbitration.
- Executes one push or pop per transaction through a 3-state FSM and reports the result on a response channel.
- Produces full/empty status and flags overflow/underflow instead of corrupting state.

---
 rtl/stack_arb_ctrl_if.sv | 51 +++++
 rtl/stack_arb_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/stack_arb_ctrl_if.sv
// Requester, response and status bundle for stack_arb_ctrl.
// top_data exists only when STACK_PEEK_EN is defined.
interface stack_arb_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int PTR_W = 3
);
    logic             req0_valid;
    logic             req0_op;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic             req1_op;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;

    logic             resp_valid;
    logic             resp_src;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;

    logic [PTR_W-1:0] sp;
    logic             full;
    logic             empty;
`ifdef STACK_PEEK_EN
    logic [WIDTH-1:0] top_data;
`endif

    modport master (
        output req0_valid, req0_op, req0_data,
        input  req0_ready,
        output req1_valid, req1_op, req1_data,
        input  req1_ready,
        input  resp_valid, resp_src, resp_data, resp_err,
        input  sp, full, empty
`ifdef STACK_PEEK_EN
        , input top_data
`endif
    );

    modport slave (
        input  req0_valid, req0_op, req0_data,
        output req0_ready,
        input  req1_valid, req1_op, req1_data,
        output req1_ready,
        output resp_valid, resp_src, resp_data, resp_err,
        output sp, full, empty
`ifdef STACK_PEEK_EN
        , output top_data
`endif
    );
endinterface

// File: rtl/stack_arb_ctrl.sv
// Two-requester round-robin LIFO stack controller: IDLE -> EXEC -> RESP per transaction.
// Define STACK_PEEK_EN to expose the current top-of-stack on bus.top_data.
module stack_arb_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    parameter int PTR_W = 3   // 2**PTR_W must exceed DEPTH
) (
    input  logic            clk,
    input  logic            resetn,
    stack_arb_ctrl_if.slave bus
);
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic             src;
        logic             op;
        logic [WIDTH-1:0] data;
    } cmd_t;

    state_t state, state_nxt;

    logic [NUM_REQ-1:0]            valid;
    logic [NUM_REQ-1:0]            op;
    logic [NUM_REQ-1:0][WIDTH-1:0] data;
    logic [NUM_REQ-1:0]            ready;

    logic                    last_grant;
    logic                    gnt_any;
    logic                    gnt_idx;
    cmd_t                    cmd;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]        sp_q;
    logic [WIDTH-1:0]        top;
    logic                    is_full;
    logic                    is_empty;

    logic             resp_valid_q;
    logic             resp_src_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_err_q;

    assign valid = {bus.req1_valid, bus.req0_valid};
    assign op    = {bus.req1_op,    bus.req0_op};
    assign data  = {bus.req1_data,  bus.req0_data};

    // Under contention the requester that did not win last time is served.
    assign gnt_any = |valid;
    assign gnt_idx = (valid == 2'b11) ? ~last_grant : valid[1];

    assign is_full  = (sp_q == PTR_W'(DEPTH));
    assign is_empty = (sp_q == '0);

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == PTR_W'(i + 1)) top = mem[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = '0;
        unique case (state)
            IDLE: begin
                if (resetn && gnt_any) begin
                    ready[gnt_idx] = 1'b1;
                    state_nxt      = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem          <= '0;
            sp_q         <= '0;
            last_grant   <= 1'b1;
            cmd          <= '0;
            resp_valid_q <= 1'b0;
            resp_src_q   <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        cmd.src    <= gnt_idx;
                        cmd.op     <= op[gnt_idx];
                        cmd.data   <= data[gnt_idx];
                        last_grant <= gnt_idx;
                    end
                end
                EXEC: begin
                    // Response registers load here so they are valid for the RESP cycle.
                    resp_valid_q <= 1'b1;
                    resp_src_q   <= cmd.src;
                    if (!cmd.op) begin
                        resp_data_q <= cmd.data;
                        if (is_full) begin
                            resp_err_q <= 1'b1;
                        end else begin
                            resp_err_q <= 1'b0;
                            for (int i = 0; i < DEPTH; i++) begin
                                if (sp_q == PTR_W'(i)) mem[i] <= cmd.data;
                            end
                            sp_q <= sp_q + PTR_W'(1);
                        end
                    end else begin
                        if (is_empty) begin
                            resp_data_q <= '0;
                            resp_err_q  <= 1'b1;
                        end else begin
                            resp_data_q <= top;
                            resp_err_q  <= 1'b0;
                            sp_q        <= sp_q - PTR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_src   = resp_src_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.sp         = sp_q;
    assign bus.full       = is_full;
    assign bus.empty      = is_empty;

`ifdef STACK_PEEK_EN
    assign bus.top_data = top;
`endif

endmodule
